fadd_seq: RTL and testbench
===========================

FADD_SEQ -- requirements
Module: fadd_seq

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of cycles operands are held stable on fa_x1/fa_x2 before the combinational adder result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_sub  input  1  1 = compute a-b, 0 = a+b.
REQ-007 req_a  input  32  IEEE-754 single operand a.
REQ-008 req_b  input  32  IEEE-754 single operand b.
REQ-009 fa_x1  output  32  registered operand to the combinational adder.
REQ-010 fa_x2  output  32  registered operand to the combinational adder, sign-adjusted.
REQ-011 fa_y  input  32  adder result.
REQ-012 fa_ovf  input  1  adder overflow indication.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer takes result.
REQ-015 rsp_data  output  32  captured result.
REQ-016 rsp_ovf  output  1  captured overflow for this result.
REQ-017 rsp_nan  output  1  rsp_data is NaN (exp 0xFF, mantissa nonzero).
REQ-018 flag_ovf  output  1  sticky overflow flag.
REQ-019 flag_nv  output  1  sticky invalid flag.
REQ-020 flag_clr  input  1  synchronous clear of both sticky flags.

Function
REQ-021 FSM states IDLE, EXEC, HOLD; 4-bit down-counter cnt.
REQ-022 req_ready SHALL be 1 in IDLE, equal rsp_ready in HOLD, 0 in EXEC.
REQ-023 Acceptance = req_valid & req_ready; on it fa_x1<=req_a, fa_x2<={req_b[31]^req_sub, req_b[30:0]}, cnt<=WAIT_CYCLES-1, state<=EXEC.
REQ-024 fa_x1/fa_x2 SHALL hold unchanged from acceptance until the next acceptance.
REQ-025 EXEC: cnt!=0 -> cnt decrements; cnt==0 -> capture rsp_data<=fa_y, rsp_ovf<=fa_ovf, rsp_nan<=NaN(fa_y), state<=HOLD.
REQ-026 rsp_valid SHALL be 1 exactly in HOLD; it rises WAIT_CYCLES cycles after the acceptance edge.
REQ-027 HOLD: rsp_valid & rsp_ready with req_valid -> new acceptance, state EXEC (back-to-back, no bubble on request side); without req_valid -> IDLE.
REQ-028 rsp_data/rsp_ovf/rsp_nan SHALL stay stable while rsp_valid & !rsp_ready.
REQ-029 Invalid at capture = NaN(fa_y) & !NaN(fa_x1) & !NaN(fa_x2).
REQ-030 At capture flag_ovf<=flag_ovf|fa_ovf, flag_nv<=flag_nv|invalid; otherwise hold.
REQ-031 flag_clr clears both flags; if clear and set occur same cycle, set wins (flag = 1).
REQ-032 req_valid in EXEC is ignored (not accepted, no state change).

Reset
REQ-033 rst asserted SHALL immediately force state IDLE, cnt 0, fa_x1/fa_x2 0, rsp_data 0, rsp_ovf/rsp_nan/rsp_valid 0, flag_ovf/flag_nv 0; req_ready 1 after release.
REQ-034 Reset during EXEC or HOLD SHALL discard the in-flight operation; no response is produced afterwards.

Verification
REQ-035 WAIT_CYCLES=2, add 0x3F800000+0x40000000 accepted edge 0 -> fa_x2=0x40000000, rsp_valid from edge 2, rsp_data 0x40400000, rsp_ovf 0.
REQ-036 Sub 0x40400000-0x3F800000 -> fa_x2=0xBF800000, rsp_data 0x40000000.
REQ-037 Add 0x7F7FFFFF+0x7F7FFFFF -> rsp_data 0x7F800000, rsp_ovf 1, flag_ovf stays 1 across later clean ops until flag_clr; flag_clr with simultaneous overflow capture -> flag_ovf 1.
REQ-038 Sub 0x7F800000-0x7F800000 -> fa_x2=0xFF800000, rsp_nan 1, flag_nv 1; NaN input 0x7FC00000+0x3F800000 -> rsp_nan 1, flag_nv unchanged.
REQ-039 rsp_ready low 5 cycles in HOLD -> rsp_data stable, req_ready 0; then rsp_ready=1 with req_valid=1 -> new request accepted same edge, next rsp_valid WAIT_CYCLES later.
REQ-040 rst pulse mid-EXEC -> all outputs 0 immediately, rsp_valid never rises for the aborted request, next request completes normally.

Source files
------------

// File: rtl/fadd_seq_if.sv
// Request/adder/response bundle for the sequenced FP adder.
// master = requester side, slave = fadd_seq side.
interface fadd_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_sub;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] fa_x1;
    logic [31:0] fa_x2;
    logic [31:0] fa_y;
    logic        fa_ovf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_nan;
    logic        flag_ovf;
    logic        flag_nv;
    logic        flag_clr;

    modport master (
        output req_valid, req_sub, req_a, req_b,
        input  req_ready,
        input  fa_x1, fa_x2,
        output fa_y, fa_ovf,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_nan,
        output rsp_ready,
        input  flag_ovf, flag_nv,
        output flag_clr
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b,
        output req_ready,
        output fa_x1, fa_x2,
        input  fa_y, fa_ovf,
        output rsp_valid, rsp_data, rsp_ovf, rsp_nan,
        input  rsp_ready,
        output flag_ovf, flag_nv,
        input  flag_clr
    );
endinterface

// File: rtl/fadd_seq.sv
// Sequencer around an external combinational FP adder: registers the
// operands, waits WAIT_CYCLES for the adder to settle, captures the result.
module fadd_seq #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    fadd_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] x1_q, x1_d;
    logic [31:0] x2_q, x2_d;
    logic [31:0] data_q, data_d;
    logic        ovf_q, ovf_d;
    logic        nan_q, nan_d;
    logic        fovf_q, fovf_d;
    logic        fnv_q, fnv_d;
    logic        ready;
    logic        accept;
    logic        capture;
    logic        y_nan;
    logic        x1_nan;
    logic        x2_nan;
    logic        invalid;

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) & (|f[22:0]);
    endfunction

    // NaN produced from non-NaN operands is an invalid operation
    assign y_nan   = is_nan(bus.fa_y);
    assign x1_nan  = is_nan(x1_q);
    assign x2_nan  = is_nan(x2_q);
    assign invalid = y_nan & ~x1_nan & ~x2_nan;

    // Next-state, handshake and capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        nan_d   = nan_q;
        ready   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ready = bus.rsp_ready;
                if (bus.rsp_ready) state_d = bus.req_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = bus.req_valid & ready;
        if (accept) begin
            x1_d  = bus.req_a;
            x2_d  = {bus.req_b[31] ^ bus.req_sub, bus.req_b[30:0]};
            cnt_d = CNT_INIT;
        end
        if (capture) begin
            data_d = bus.fa_y;
            ovf_d  = bus.fa_ovf;
            nan_d  = y_nan;
        end
        // a set arriving with a clear wins
        fovf_d = (fovf_q & ~bus.flag_clr) | (capture & bus.fa_ovf);
        fnv_d  = (fnv_q & ~bus.flag_clr) | (capture & invalid);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            x1_q    <= 32'd0;
            x2_q    <= 32'd0;
            data_q  <= 32'd0;
            ovf_q   <= 1'b0;
            nan_q   <= 1'b0;
            fovf_q  <= 1'b0;
            fnv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            nan_q   <= nan_d;
            fovf_q  <= fovf_d;
            fnv_q   <= fnv_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.fa_x1     = x1_q;
    assign bus.fa_x2     = x2_q;
    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.rsp_nan   = nan_q;
    assign bus.flag_ovf  = fovf_q;
    assign bus.flag_nv   = fnv_q;

endmodule

// File: tb/tb_fadd_seq.sv
// Bench for fadd_seq: directed vector table, reset abort, randomized
// transactions against a real-arithmetic reference of the adder.
module tb_fadd_seq;

    localparam int WAIT = 2;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;
    logic m_fo;
    logic m_fn;

    fadd_seq_if bus();

    fadd_seq #(.WAIT_CYCLES(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) & (|f[22:0]);
    endfunction

    // float32 -> float64 bit pattern (subnormals flushed to zero)
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return {f[31], 63'd0};
        if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'd0};
        e = {3'd0, f[30:23]} + 11'd896;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    // Reference adder: {ovf, sum} rounded to nearest even
    function automatic logic [32:0] fp_add(input logic [31:0] x1, input logic [31:0] x2);
        real         r;
        logic [63:0] d;
        logic [23:0] m;
        logic [31:0] y;
        logic        ov;
        int          e;
        r = $bitstoreal(f2d(x1)) + $bitstoreal(f2d(x2));
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) begin
            y = (d[51:0] != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
        end else if (d[62:52] == 11'd0) begin
            y = {d[63], 31'd0};
        end else begin
            e = int'(d[62:52]) - 1023 + 127;
            m = {1'b0, d[51:29]};
            if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
            if (m[23]) begin
                m = 24'd0;
                e = e + 1;
            end
            if (e >= 255) y = {d[63], 8'hFF, 23'd0};
            else if (e <= 0) y = {d[63], 31'd0};
            else y = {d[63], e[7:0], m[22:0]};
        end
        ov = (y[30:0] == 31'h7F800000) && (x1[30:23] != 8'hFF) && (x2[30:23] != 8'hFF);
        return {ov, y};
    endfunction

    // Combinational adder sitting between fa_x1/fa_x2 and fa_y/fa_ovf
    always_comb {bus.fa_ovf, bus.fa_y} = fp_add(bus.fa_x1, bus.fa_x2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction. from_hold: previous response is consumed on the
    // acceptance edge. stay: leave the response pending in HOLD.
    task automatic op(
        input logic [31:0] a, input logic [31:0] b, input logic sub,
        input logic clr, input int stall, input logic from_hold, input logic stay,
        input logic [31:0] ex2, input logic [31:0] ey,
        input logic eov, input logic enan, input logic efo, input logic efn
    );
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        bus.req_valid = 1'b1;
        bus.rsp_ready = from_hold;
        bus.flag_clr  = 1'b0;
        #1;
        chkb("req_ready_accept", bus.req_ready, 1'b1);
        tick();
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.rsp_ready = 1'b0;
        chk("fa_x1", bus.fa_x1, a);
        chk("fa_x2", bus.fa_x2, ex2);
        for (int n = 1; n <= WAIT; n++) begin
            bus.req_valid = 1'($urandom % 2);
            bus.flag_clr  = (n == WAIT) ? clr : 1'b0;
            #1;
            chkb("rsp_valid_exec", bus.rsp_valid, 1'b0);
            chkb("req_ready_exec", bus.req_ready, 1'b0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.flag_clr  = 1'b0;
        chkb("rsp_valid_rise", bus.rsp_valid, 1'b1);
        chk("rsp_data", bus.rsp_data, ey);
        chkb("rsp_ovf", bus.rsp_ovf, eov);
        chkb("rsp_nan", bus.rsp_nan, enan);
        chkb("flag_ovf", bus.flag_ovf, efo);
        chkb("flag_nv", bus.flag_nv, efn);
        chk("fa_x1_hold", bus.fa_x1, a);
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            bus.req_a     = $urandom;
            #1;
            chkb("req_ready_stall", bus.req_ready, 1'b0);
            tick();
            chkb("rsp_valid_stall", bus.rsp_valid, 1'b1);
            chk("rsp_data_stall", bus.rsp_data, ey);
            chkb("rsp_ovf_stall", bus.rsp_ovf, eov);
            chk("fa_x2_stall", bus.fa_x2, ex2);
        end
        bus.req_valid = 1'b0;
        if (!stay) begin
            bus.rsp_ready = 1'b1;
            #1;
            chkb("req_ready_hold", bus.req_ready, 1'b1);
            tick();
            bus.rsp_ready = 1'b0;
            chkb("rsp_valid_drop", bus.rsp_valid, 1'b0);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom % 10)
            0: return 32'h00000000;
            1: return 32'h7F800000;
            2: return 32'h7FC00000;
            3: return 32'h7F7FFFFF;
            4: return 32'hFF7FFFFF;
            5: return 32'h3F800000;
            default: return $urandom;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        clr;
        logic [31:0] x2;
        logic [31:0] y;
        logic        ov;
        logic        nn;
        logic        fo;
        logic        fn;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] a, b, bx, y;
        logic [32:0] r;
        logic        sub, clr, ov, nn, stay, from_hold;
        int          stall;

        nvec  = 0;
        nfail = 0;
        tbl[0] = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_sub   = 1'b0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;
        bus.flag_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_fa_x1", bus.fa_x1, 32'd0);
        chk("rst_fa_x2", bus.fa_x2, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chkb("rst_flag_ovf", bus.flag_ovf, 1'b0);
        chkb("rst_flag_nv", bus.flag_nv, 1'b0);
        rst = 1'b0;
        #1;
        chkb("rst_req_ready", bus.req_ready, 1'b1);
        tick();

        for (int i = 0; i < 9; i++) begin
            op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].clr, 0, 1'b0, 1'b0,
               tbl[i].x2, tbl[i].y, tbl[i].ov, tbl[i].nn, tbl[i].fo, tbl[i].fn);
        end

        // reset in the middle of EXEC discards the operation
        op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0,
           32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.req_a     = 32'h3F800000;
        bus.req_b     = 32'h40000000;
        bus.req_sub   = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        #1;
        rst = 1'b1;
        #1;
        chkb("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_fa_x1", bus.fa_x1, 32'd0);
        chk("abort_fa_x2", bus.fa_x2, 32'd0);
        chk("abort_rsp_data", bus.rsp_data, 32'd0);
        chkb("abort_rsp_ovf", bus.rsp_ovf, 1'b0);
        chkb("abort_rsp_nan", bus.rsp_nan, 1'b0);
        chkb("abort_flag_ovf", bus.flag_ovf, 1'b0);
        chkb("abort_flag_nv", bus.flag_nv, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chkb("abort_req_ready", bus.req_ready, 1'b1);
        for (int n = 0; n < WAIT + 3; n++) begin
            tick();
            chkb("abort_no_rsp", bus.rsp_valid, 1'b0);
        end
        op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 0, 1'b0, 1'b0,
           32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized traffic with stalls and back-to-back requests
        m_fo      = 1'b0;
        m_fn      = 1'b0;
        from_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a     = rnd_op();
            b     = rnd_op();
            sub   = 1'($urandom % 2);
            clr   = (($urandom % 4) == 0);
            stall = (i == 0) ? 5 : int'($urandom % 4);
            stay  = (i == 0) ? 1'b1 : ((i == 39) ? 1'b0 : 1'($urandom % 2));
            bx    = {b[31] ^ sub, b[30:0]};
            r     = fp_add(a, bx);
            y     = r[31:0];
            ov    = r[32];
            nn    = is_nan(y);
            if (clr) begin
                m_fo = 1'b0;
                m_fn = 1'b0;
            end
            m_fo = m_fo | ov;
            m_fn = m_fn | (nn & !is_nan(a) & !is_nan(bx));
            op(a, b, sub, clr, stall, from_hold, stay, bx, y, ov, nn, m_fo, m_fn);
            from_hold = stay;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
